writeback_queue_mod: RTL

//  Writer side of the register file write port (address3/write_data3/write_en3).

---
 rtl/writeback_queue_mod.sv | 108 ++++++++++
 1 files changed

// File: rtl/writeback_queue_mod.sv
// Register file write-port queue: buffers ALU and load results, drains one
// per cycle into address3/write_data3/write_en3 and forwards pending data.
module writeback_queue_mod #(
   parameter int DEPTH   = 4,
   parameter bit DROP_R0 = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid_i,
   output logic                       alu_ready_o,
   input  logic [0:4]                 alu_rd_i,
   input  logic [0:33]                alu_data_i,
   input  logic                       mem_valid_i,
   output logic                       mem_ready_o,
   input  logic [0:4]                 mem_rd_i,
   input  logic [0:33]                mem_data_i,
   output logic [0:4]                 address3_o,
   output logic [0:33]                write_data3_o,
   output logic                       write_en3_o,
   input  logic [0:4]                 fwd_addr1_i,
   input  logic [0:4]                 fwd_addr2_i,
   output logic                       fwd_hit1_o,
   output logic [0:33]                fwd_data1_o,
   output logic                       fwd_hit2_o,
   output logic [0:33]                fwd_data2_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [0:4]    rd_q   [DEPTH];
   logic [0:33]   data_q [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] mem_ptr;
   logic [AW-1:0] idx;
   logic [CW-1:0] count;
   logic          pop;
   logic          alu_drop;
   logic          mem_drop;
   logic          enq_alu;
   logic          enq_mem;

   // Readies look only at the registered count, never at the drain.
   assign alu_ready_o = count < CW'(DEPTH);
   assign mem_ready_o = (count <= CW'(DEPTH - 2)) |
                        ((count == CW'(DEPTH - 1)) & ~alu_valid_i);

   assign alu_drop = DROP_R0 && (alu_rd_i == 5'd0);
   assign mem_drop = DROP_R0 && (mem_rd_i == 5'd0);
   assign enq_alu  = alu_valid_i & alu_ready_o & ~alu_drop;
   assign enq_mem  = mem_valid_i & mem_ready_o & ~mem_drop;
   assign mem_ptr  = wr_ptr + AW'(enq_alu);
   assign pop      = (count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop);
         wr_ptr <= wr_ptr + AW'(enq_alu) + AW'(enq_mem);
         count  <= count + CW'(enq_alu) + CW'(enq_mem) - CW'(pop);
      end
   end

   // Payload needs no reset: an entry is live only while inside count.
   always_ff @(posedge clk) begin
      if (enq_alu) begin
         rd_q[wr_ptr]   <= alu_rd_i;
         data_q[wr_ptr] <= alu_data_i;
      end
      if (enq_mem) begin
         rd_q[mem_ptr]   <= mem_rd_i;
         data_q[mem_ptr] <= mem_data_i;
      end
   end

   assign write_en3_o   = pop;
   assign address3_o    = pop ? rd_q[rd_ptr] : '0;
   assign write_data3_o = pop ? data_q[rd_ptr] : '0;
   assign occupancy_o   = count;

   // Walk oldest to youngest so the last match seen is the youngest.
   always_comb begin
      fwd_hit1_o  = 1'b0;
      fwd_data1_o = '0;
      fwd_hit2_o  = 1'b0;
      fwd_data2_o = '0;
      idx         = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + AW'(k);
         if (CW'(k) < count) begin
            if (rd_q[idx] == fwd_addr1_i) begin
               fwd_hit1_o  = 1'b1;
               fwd_data1_o = data_q[idx];
            end
            if (rd_q[idx] == fwd_addr2_i) begin
               fwd_hit2_o  = 1'b1;
               fwd_data2_o = data_q[idx];
            end
         end
      end
   end

endmodule
